// File: rtl/add_sub_arbiter_if.sv
// Request/response bundle between the two ALU front-end requesters and add_sub_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface add_sub_arbiter_if #(parameter int OPW = 3);
  logic           req0_valid, req0_ready, req0_op;
  logic [OPW-1:0] req0_a, req0_b;
  logic           req1_valid, req1_ready, req1_op;
  logic [OPW-1:0] req1_a, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [OPW:0]   rsp_c;
  logic           rsp_sign, rsp_zero, rsp_err;
  logic           busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// Two-requester arbiter/sequencer around a sign-magnitude add_sub unit.
// Define ADD_SUB_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).

// Combinational sign-magnitude adder/subtractor; result is OPW+1 bits, sign in MSB, zero is +0.
module add_sub #(parameter int OPW = 3) (
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  input  logic           ctrl_i,
  output logic [OPW:0]   c_o,
  output logic           sign_o,
  output logic           zero_o
);
  logic           sa, sb, s;
  logic [OPW-1:0] ma, mb, mag;

  always_comb begin
    sa  = a_i[OPW-1];
    sb  = b_i[OPW-1] ^ ctrl_i;
    ma  = {1'b0, a_i[OPW-2:0]};
    mb  = {1'b0, b_i[OPW-2:0]};
    mag = '0;
    s   = 1'b0;
    if (sa == sb) begin
      mag = ma + mb;
      s   = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      s   = sa;
    end else begin
      mag = mb - ma;
      s   = sb;
    end
    if (mag == '0) s = 1'b0;
    c_o    = {s, mag};
    sign_o = s;
    zero_o = (mag == '0);
  end
endmodule

module add_sub_arbiter #(parameter int OPW = 3) (
  input logic               clk,
  input logic               rst_n,
  add_sub_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           op;
    logic           id;
  } req_t;

  state_e       state_q;
  req_t         opr_q, gnt_req;
  logic         busy_q, rsp_valid_q, rsp_id_q, rsp_sign_q, rsp_zero_q, rsp_err_q;
  logic [OPW:0] rsp_c_q;
  logic         gnt_vld, gnt_id, accept;
  logic [OPW:0] as_c;
  logic         as_sign, as_zero;
`ifdef ADD_SUB_ARB_RR_EN
  logic         ptr_q;
`endif

  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
`ifdef ADD_SUB_ARB_RR_EN
    // Pointer only decides ties; a lone requester always wins.
    if (bus.req0_valid && bus.req1_valid) gnt_id = ptr_q;
    else                                  gnt_id = ~bus.req0_valid;
`else
    gnt_id  = ~bus.req0_valid;
`endif
    accept     = (state_q == IDLE) & gnt_vld;
    gnt_req.a  = gnt_id ? bus.req1_a  : bus.req0_a;
    gnt_req.b  = gnt_id ? bus.req1_b  : bus.req0_b;
    gnt_req.op = gnt_id ? bus.req1_op : bus.req0_op;
    gnt_req.id = gnt_id;
  end

  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept &  gnt_id;

  add_sub #(.OPW(OPW)) u_add_sub (
    .a_i    (opr_q.a),
    .b_i    (opr_q.b),
    .ctrl_i (opr_q.op),
    .c_o    (as_c),
    .sign_o (as_sign),
    .zero_o (as_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opr_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= '0;
      rsp_sign_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ADD_SUB_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          opr_q   <= gnt_req;
          busy_q  <= 1'b1;
          state_q <= EXEC;
`ifdef ADD_SUB_ARB_RR_EN
          ptr_q   <= ~gnt_id;
`endif
        end
        EXEC: begin
          rsp_c_q     <= as_c;
          rsp_sign_q  <= as_sign;
          rsp_zero_q  <= as_zero;
          rsp_id_q    <= opr_q.id;
          // Cross-check flags against C so a faulty datapath is visible downstream.
          rsp_err_q   <= (as_zero != ~|as_c[OPW-1:0]) | (as_sign != as_c[OPW]);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_sign  = rsp_sign_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Two-requester arbiter and sequencer for the shared `add_sub` unit. It accepts 3-bit sign-magnitude add/subtract requests from two requesters over valid/ready handshakes and drives one request at a time into its internal `add_sub` instance. It registers the 4-bit result and flags and returns them on a single tagged response channel. It sits between the ALU front-end ports and the combinational add/sub datapath.

## Interface
- `OPW`, 3, operand width; must equal the `add_sub` operand width (3); result width is `OPW+1`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  OPW  sign-magnitude operands (bit 2 = sign, bits 1:0 = magnitude).
- `req0_op` / `req1_op`  in  1  0 = A+B, 1 = A−B (drives `add_sub` `ctrl`).
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  index of the requester that issued the response.
- `rsp_c`  out  OPW+1  registered `add_sub` C (bit 3 = sign).
- `rsp_sign`, `rsp_zero`  out  1  registered `add_sub` sign and zero flags.
- `rsp_err`  out  1  high when the captured flags are inconsistent with the captured C.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- In IDLE, the arbiter picks a grant from `req*_valid` and the priority pointer.
  - `reqX_ready = (state==IDLE) & grant==X`. It is combinational, and at most one ready is high.
  - No valid request: no ready is asserted and the FSM stays in IDLE.
- IDLE → EXEC on the handshake edge.
  - Latched into operand registers: the granted a, b, op and id.
  - Those registers drive `add_sub` A, B and ctrl.
  - The priority pointer updates (see Configuration).
- EXEC → RESP unconditionally after one cycle. On that edge:
  - `rsp_c`, `rsp_sign`, `rsp_zero` and `rsp_id` capture the `add_sub` outputs and the latched id.
  - `rsp_err` captures `(zero != ~|C[2:0]) | (sign != C[3])`.
- RESP → IDLE on the edge where `rsp_valid & rsp_ready`.
  - Response registers hold their values until the next capture.
  - No request is accepted in RESP.
- Requesters hold valid, operands and op stable until ready. A request whose valid is dropped before grant is not accepted.
- Arithmetic is entirely inside `add_sub`. The arbiter neither modifies nor sign-extends operands or results.

## Timing
- Reset (`rst_n`=0 at a rising edge), effective at the next edge:
  - Outputs: state IDLE, `busy`=0, `rsp_valid`=0, `req*_ready` = combinational from IDLE, `rsp_c`=0000, `rsp_sign`=0, `rsp_zero`=0, `rsp_err`=0, `rsp_id`=0.
  - Priority pointer: req0.
- Reset mid-operation in EXEC or RESP discards the in-flight op. No response is issued, and a pending `rsp_valid` drops after the reset edge.
- Latency:
  - Accept edge N, so EXEC is cycle N+1.
  - `rsp_valid`=1 from cycle N+2.
  - With `rsp_ready` held high: IDLE at N+3, next accept at edge N+3 at the earliest.
  - Throughput: 1 op per 3 cycles.
- Backpressure: while `rsp_ready`=0 in RESP, all `rsp_*` outputs are stable and both `req*_ready`=0.
- Simultaneous valid: exactly one ready, chosen per the priority pointer. The loser keeps valid high and is served on the next IDLE grant.
- `rsp_valid`=1 only in RESP; `busy` = EXEC | RESP.

## Configuration
- `ADD_SUB_ARB_RR_EN` defined: round-robin.
  - After granting requester X, the pointer favours requester 1−X.
  - A lone valid requester is always granted regardless of the pointer.
- Undefined: fixed priority. req0 wins whenever `req0_valid`=1; the pointer logic is not built.

## Test plan
- Single add: req0 a=011, b=001, op=0, accepted at edge N.
  - Expect at N+2: `rsp_valid`=1, `rsp_id`=0, `rsp_c`=0100, sign=0, zero=0, err=0.
- Subtract with negative result: req1 a=001, b=011, op=1.
  - Expect `rsp_id`=1, `rsp_c`=1010, sign=1, zero=0.
- Zero result: req0 a=010, b=010, op=1.
  - Expect `rsp_c` magnitude 000, zero=1, err=0.
- Contention: both valid held for 6 ops, `rsp_ready`=1.
  - With `ADD_SUB_ARB_RR_EN`: `rsp_id` sequence 0,1,0,1,0,1.
  - Without it: 0,0,0,0,0,0.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_*` outputs are unchanged and both `req*_ready`=0.
  - Raising `rsp_ready` returns the FSM to IDLE on the next edge.
- Reset mid-EXEC: assert `rst_n`=0 one cycle after an accept.
  - Expect `rsp_valid` to stay 0, `busy`=0, and all `rsp_*`=0 after the edge.
  - The next request is accepted from IDLE with pointer req0.
